// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and issues reads to a 1-cycle synchronous
// instruction memory. Returned words are queued in a 2-entry buffer that feeds IF/ID.
module if_fetch_stage #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_data,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_4
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [31:0]       slot_inst [2];
  logic [ADDR_W-1:0] slot_pc   [2];

  logic              head_vld;
  logic              pop;
  logic              push;
  logic              issue;
  logic              flush;
  logic              wr_sel;
  logic [2:0]        occ;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  assign head_vld = (state == RUN) && (count != 2'd0);
  assign pop      = en && !stall && head_vld && !redirect && !halt;
  // Slots that will be occupied once this cycle's pop and in-flight arrival settle.
  assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  // Arrival lands just behind whatever survives this cycle's pop.
  assign wr_sel   = (count == 2'd2) || ((count == 2'd1) && !pop);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    im_addr   = fetch_pc;
    if (state == RUN) begin
      if (en && halt) begin
        state_nxt = HALTED;
        flush     = 1'b1;
      end else if (en && redirect) begin
        flush   = 1'b1;
        issue   = !rst;
        im_addr = redirect_pc;
      end else begin
        push  = inflight;
        issue = en && !rst && (occ <= 3'd1);
      end
    end
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      count_nxt = count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign im_req = issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch control: PC, buffer occupancy and outstanding-read flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      count    <= count_nxt;
      inflight <= issue;
      if (issue) begin
        fetch_pc <= pc_inc(im_addr);
      end
    end
  end

  // Buffer data: slot 0 is the head; a pop shifts slot 1 forward.
  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc <= im_addr;
    end
    if (pop) begin
      slot_inst[0] <= slot_inst[1];
      slot_pc[0]   <= slot_pc[1];
    end
    if (push) begin
      slot_inst[wr_sel] <= im_data;
      slot_pc[wr_sel]   <= inflight_pc;
    end
  end

  assign out_valid = head_vld;
  assign out_inst  = head_vld ? slot_inst[0]      : 32'd0;
  assign out_pc    = head_vld ? slot_pc[0]        : '0;
  assign out_pc_4  = head_vld ? pc_inc(slot_pc[0]) : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: queue-based reference of PCs in flight and buffered,
// with a memory whose contents are a fixed function of the address.
module tb_if_fetch_stage;
  localparam int                ADDR_W   = 10;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_data = 32'd0;
  logic              out_valid;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_4;

  if_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .im_req(im_req), .im_addr(im_addr),
    .im_data(im_data), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_4(out_pc_4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous memory: data for a request appears the following cycle; junk otherwise.
  always @(posedge clk) im_data <= im_req ? word(im_addr) : $urandom;

  bit                m_halted;
  logic [ADDR_W-1:0] m_fetch;
  logic [ADDR_W-1:0] m_buf[$];
  logic [ADDR_W-1:0] m_infl[$];
  int                checks = 0;
  int                fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the reference, then advance it.
  task automatic step(input bit e, input bit s, input bit r,
                      input logic [ADDR_W-1:0] rp, input bit h);
    bit                v, p, ereq;
    logic [ADDR_W-1:0] hp, hp4, eaddr;
    int                occ;
    en = e; stall = s; redirect = r; redirect_pc = rp; halt = h;
    #1;
    v   = !m_halted && (m_buf.size() > 0);
    hp  = v ? m_buf[0] : '0;
    hp4 = hp + 1'b1;
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_pc", 32'(out_pc), 32'(hp));
    chk("out_pc_4", 32'(out_pc_4), v ? 32'(hp4) : 32'd0);
    chk("out_inst", out_inst, v ? word(hp) : 32'd0);
    p     = e && !s && v && !r && !h;
    occ   = m_buf.size() + m_infl.size() - (p ? 1 : 0);
    ereq  = 1'b0;
    eaddr = m_fetch;
    if (!m_halted && e && !h) begin
      if (r) begin
        ereq  = 1'b1;
        eaddr = rp;
      end else if (occ <= 1) begin
        ereq = 1'b1;
      end
    end
    chk("im_req", 32'(im_req), 32'(ereq));
    if (ereq) chk("im_addr", 32'(im_addr), 32'(eaddr));
    if (!m_halted) begin
      if (e && h) begin
        m_halted = 1'b1;
        m_buf.delete();
        m_infl.delete();
      end else begin
        if (e && r) begin
          m_buf.delete();
        end else begin
          if (p) void'(m_buf.pop_front());
          if (m_infl.size() > 0) m_buf.push_back(m_infl[0]);
        end
        m_infl.delete();
        if (ereq) begin
          m_infl.push_back(eaddr);
          m_fetch = eaddr + 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_out_pc_4", 32'(out_pc_4), 32'd0);
    m_halted = 1'b0;
    m_fetch  = RESET_PC;
    m_buf.delete();
    m_infl.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    en = 1'b1;
    @(negedge clk);
    do_reset();

    // Stream from reset: cycles 0..6
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("stream_addr", 32'(im_addr), 32'(c));
      if (c >= 2) begin
        chk("stream_pc", 32'(out_pc), 32'(c - 2));
        chk("stream_pc_4", 32'(out_pc_4), 32'(c - 1));
      end
      @(negedge clk);
    end

    // Stall with head pc=5 and pc=6 in flight
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk("stall_head", 32'(out_pc), 32'd5);
      if (c > 0) chk("stall_no_req", 32'(im_req), 32'd0);
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("release_pc", 32'(out_pc), 32'(5 + c));
      @(negedge clk);
    end

    // Redirect while head pc=8
    step(1'b1, 1'b0, 1'b1, 10'h040, 1'b0);
    chk("redir_head", 32'(out_pc), 32'd8);
    chk("redir_addr", 32'(im_addr), 32'h40);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("redir_bubble", 32'(out_valid), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("redir_pc", 32'(out_pc), 32'(32'h40 + c));
      @(negedge clk);
    end

    // Redirect together with stall
    step(1'b1, 1'b1, 1'b1, 10'h100, 1'b0);
    chk("rs_addr", 32'(im_addr), 32'h100);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rs_bubble", 32'(out_valid), 32'd0);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rs_target", 32'(out_pc), 32'h100);
    @(negedge clk);

    // Address wrap
    step(1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("wrap_pc_a", 32'(out_pc), 32'h3FF);
    chk("wrap_pc4_a", 32'(out_pc_4), 32'h000);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("wrap_pc_b", 32'(out_pc), 32'h000);
    chk("wrap_pc4_b", 32'(out_pc_4), 32'h001);
    @(negedge clk);

    // Halt is sticky until reset
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("halt_req", 32'(im_req), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 10'($urandom), 1'b0);
      chk("halted_valid", 32'(out_valid), 32'd0);
      chk("halted_req", 32'(im_req), 32'd0);
      @(negedge clk);
    end
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("restart_addr", 32'(im_addr), 32'(RESET_PC));
    @(negedge clk);

    // Randomized traffic with occasional halts and mid-run resets
    for (int i = 0; i < 4000; i++) begin
      if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, 10'($urandom), $urandom_range(0, 299) == 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
